// File: rtl/nv_nvdla_sdp_mcif_wr_rsp.sv
// Memory-side responder for the SDP write-DMA request stream: commits data beats to a
// flat 64-bit write port and returns a delayed complete pulse for ack-requesting commands.
module nv_nvdla_sdp_mcif_wr_rsp #(
  parameter int ACK_LATENCY     = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        wr_req_valid,
  output logic        wr_req_ready,
  input  logic [65:0] wr_req_pd,
  input  logic        rsp_stall,
  output logic        wr_rsp_complete,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output logic [63:0] mem_wr_data,
  output logic        mem_wr_mask,
  output logic [7:0]  outstanding_cnt,
  output logic        prot_err
);

  localparam logic [7:0] MAX_OUT_C = 8'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

  state_t                 state_r;
  logic [31:0]            beat_addr_r;
  logic [12:0]            beats_left_r;
  logic                   ack_req_r;
  logic [ACK_LATENCY-1:0] ack_pipe_r;

  logic ready_s;
  logic xfer_s;
  logic cmd_xfer_s;
  logic beat_xfer_s;
  logic last_beat_s;
  logic proto_err_s;
  logic ack_load_s;
  logic cnt_inc_s;
  logic cnt_dec_s;

  // Ready generation: reset and stall force it low; the outstanding limit applies only to new commands.
  always_comb begin
    ready_s = 1'b0;
    if (!nvdla_core_rstn) begin
      ready_s = 1'b0;
    end else if (rsp_stall) begin
      ready_s = 1'b0;
    end else if (state_r == ST_DATA) begin
      ready_s = 1'b1;
    end else begin
      ready_s = (outstanding_cnt < MAX_OUT_C);
    end
  end

  assign wr_req_ready = ready_s;

  // Transfer decode against the current state, including out-of-order packet types.
  always_comb begin
    xfer_s      = wr_req_valid & ready_s;
    cmd_xfer_s  = 1'b0;
    beat_xfer_s = 1'b0;
    proto_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_xfer_s  = xfer_s & ~wr_req_pd[65];
        proto_err_s = xfer_s & wr_req_pd[65];
      end
      ST_DATA: begin
        beat_xfer_s = xfer_s & wr_req_pd[65];
        proto_err_s = xfer_s & ~wr_req_pd[65];
      end
      default: begin
        cmd_xfer_s  = 1'b0;
        beat_xfer_s = 1'b0;
        proto_err_s = 1'b0;
      end
    endcase
    last_beat_s = beat_xfer_s & (beats_left_r == 13'd0);
    ack_load_s  = last_beat_s & ack_req_r;
    cnt_inc_s   = cmd_xfer_s & wr_req_pd[45];
    cnt_dec_s   = wr_rsp_complete & (outstanding_cnt != 8'd0);
  end

  // Command/beat sequencing; a stray command in DATA is dropped without disturbing the burst.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_r      <= ST_IDLE;
      beat_addr_r  <= 32'd0;
      beats_left_r <= 13'd0;
      ack_req_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_xfer_s) begin
            state_r      <= ST_DATA;
            beat_addr_r  <= {wr_req_pd[31:3], 3'b000};
            beats_left_r <= wr_req_pd[44:32];
            ack_req_r    <= wr_req_pd[45];
          end
        end
        ST_DATA: begin
          if (beat_xfer_s) begin
            beat_addr_r <= beat_addr_r + 32'd8;
            if (beats_left_r == 13'd0) begin
              state_r <= ST_IDLE;
            end else begin
              beats_left_r <= beats_left_r - 13'd1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Registered memory write port, one cycle behind the beat transfer.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= 32'd0;
      mem_wr_data <= 64'd0;
      mem_wr_mask <= 1'b0;
    end else begin
      mem_wr_en <= beat_xfer_s;
      if (beat_xfer_s) begin
        mem_wr_addr <= beat_addr_r;
        mem_wr_data <= wr_req_pd[63:0];
        mem_wr_mask <= wr_req_pd[64];
      end
    end
  end

  // Ack delay line; its last stage is the complete pulse.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      ack_pipe_r <= '0;
    end else begin
      ack_pipe_r[0] <= ack_load_s;
      for (int i = 1; i < ACK_LATENCY; i++) begin
        ack_pipe_r[i] <= ack_pipe_r[i-1];
      end
    end
  end

  assign wr_rsp_complete = ack_pipe_r[ACK_LATENCY-1];

  // Outstanding ack-requesting command count.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      outstanding_cnt <= 8'd0;
    end else begin
      case ({cnt_inc_s, cnt_dec_s})
        2'b10:   outstanding_cnt <= outstanding_cnt + 8'd1;
        2'b01:   outstanding_cnt <= outstanding_cnt - 8'd1;
        default: outstanding_cnt <= outstanding_cnt;
      endcase
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      prot_err <= 1'b0;
    end else if (proto_err_s) begin
      prot_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_sdp_mcif_wr_rsp.sv
// Directed bench: dut0 uses default parameters, dut1 uses ACK_LATENCY=16 / MAX_OUTSTANDING=2.
module tb_nv_nvdla_sdp_mcif_wr_rsp;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid = 1'b0;
  logic        sel = 1'b0;
  logic [65:0] pd = 66'd0;
  logic        stall = 1'b0;

  logic        r0, r1, cmp0, cmp1, we0, we1, wm0, wm1, pe0, pe1;
  logic [31:0] wa0, wa1;
  logic [63:0] wd0, wd1;
  logic [7:0]  cnt0, cnt1;

  int cyc = 0;
  int chk_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
    logic        m;
    int          c;
  } wr_t;

  wr_t wq0[$];
  int  cq0[$];
  int  cq1[$];
  int  last_xc;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  nv_nvdla_sdp_mcif_wr_rsp #(.ACK_LATENCY(4), .MAX_OUTSTANDING(8)) dut0 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .wr_req_valid(valid & ~sel),
    .wr_req_ready(r0), .wr_req_pd(pd), .rsp_stall(stall), .wr_rsp_complete(cmp0),
    .mem_wr_en(we0), .mem_wr_addr(wa0), .mem_wr_data(wd0), .mem_wr_mask(wm0),
    .outstanding_cnt(cnt0), .prot_err(pe0));

  nv_nvdla_sdp_mcif_wr_rsp #(.ACK_LATENCY(16), .MAX_OUTSTANDING(2)) dut1 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .wr_req_valid(valid & sel),
    .wr_req_ready(r1), .wr_req_pd(pd), .rsp_stall(stall), .wr_rsp_complete(cmp1),
    .mem_wr_en(we1), .mem_wr_addr(wa1), .mem_wr_data(wd1), .mem_wr_mask(wm1),
    .outstanding_cnt(cnt1), .prot_err(pe1));

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we0) wq0.push_back('{a: wa0, d: wd0, m: wm0, c: cyc});
    if (cmp0) cq0.push_back(cyc);
    if (cmp1) cq1.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [65:0] cmd_pd(input logic [31:0] addr, input logic [12:0] size, input logic ack);
    return {1'b0, 19'd0, ack, size, addr};
  endfunction

  function automatic logic [65:0] dat_pd(input logic [63:0] d, input logic m);
    return {1'b1, m, d};
  endfunction

  // Present one packet and hold it until accepted; last_xc is the transfer edge.
  task automatic send(input logic [65:0] p);
    int n;
    n = 0;
    valid = 1'b1;
    pd = p;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? r1 : r0) && n < 200);
    if (!(sel ? r1 : r0)) begin
      check_eq("send_timeout", 64'd0, 64'd1);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_xc = cyc;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int x3, xa, xb, xc3, xd, xe;

  initial begin
    // Reset state
    @(negedge clk);
    check_eq("rst_ready", 64'(r0), 64'd0);
    idle(2);
    check_eq("rst_we", 64'(we0), 64'd0);
    check_eq("rst_cnt", 64'(cnt0), 64'd0);
    check_eq("rst_perr", 64'(pe0), 64'd0);
    check_eq("rst_cmp", 64'(cmp0), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 64'(r0), 64'd1);
    idle(1);

    // 1: single command, 4 beats, ack
    wq0.delete(); cq0.delete();
    send(cmd_pd(32'h1000_0003, 13'd3, 1'b1));
    check_eq("t1_cnt_inc", 64'(cnt0), 64'd1);
    for (int i = 0; i < 4; i++) send(dat_pd(64'hA5A5_0000_0000_0000 + 64'(i), i[0]));
    x3 = last_xc;
    idle(8);
    check_eq("t1_nwr", 64'(wq0.size()), 64'd4);
    for (int i = 0; i < wq0.size(); i++) begin
      check_eq("t1_addr", 64'(wq0[i].a), 64'(32'h1000_0000 + 32'(8 * i)));
      check_eq("t1_data", wq0[i].d, 64'hA5A5_0000_0000_0000 + 64'(i));
      check_eq("t1_mask", 64'(wq0[i].m), 64'(i % 2));
      check_eq("t1_cyc", 64'(wq0[i].c), 64'(x3 - 3 + i));
    end
    check_eq("t1_ncmp", 64'(cq0.size()), 64'd1);
    if (cq0.size() > 0) check_eq("t1_cmp_cyc", 64'(cq0[0]), 64'(x3 + 3));
    check_eq("t1_cnt_dec", 64'(cnt0), 64'd0);

    // 2: address wrap, no ack
    wq0.delete(); cq0.delete();
    send(cmd_pd(32'hFFFF_FFF8, 13'd1, 1'b0));
    check_eq("t2_cnt", 64'(cnt0), 64'd0);
    send(dat_pd(64'h1111_2222_3333_4444, 1'b0));
    send(dat_pd(64'h5555_6666_7777_8888, 1'b1));
    idle(10);
    check_eq("t2_nwr", 64'(wq0.size()), 64'd2);
    if (wq0.size() == 2) begin
      check_eq("t2_addr0", 64'(wq0[0].a), 64'hFFFF_FFF8);
      check_eq("t2_addr1", 64'(wq0[1].a), 64'h0000_0000);
      check_eq("t2_data1", wq0[1].d, 64'h5555_6666_7777_8888);
    end
    check_eq("t2_ncmp", 64'(cq0.size()), 64'd0);
    check_eq("t2_cnt_end", 64'(cnt0), 64'd0);

    // 3: outstanding limit on dut1
    sel = 1'b1; cq1.delete();
    send(cmd_pd(32'h0000_0100, 13'd0, 1'b1));
    send(dat_pd(64'hA, 1'b0)); xa = last_xc;
    send(cmd_pd(32'h0000_0200, 13'd0, 1'b1));
    send(dat_pd(64'hB, 1'b0)); xb = last_xc;
    @(negedge clk);
    check_eq("t3_cnt_full", 64'(cnt1), 64'd2);
    check_eq("t3_ready_low", 64'(r1), 64'd0);
    send(cmd_pd(32'h0000_0300, 13'd0, 1'b1)); xc3 = last_xc;
    check_eq("t3_cmd3_cyc", 64'(xc3), 64'(xa + 17));
    send(dat_pd(64'hC, 1'b0)); xd = last_xc;
    idle(20);
    check_eq("t3_ncmp", 64'(cq1.size()), 64'd3);
    if (cq1.size() == 3) begin
      check_eq("t3_cmp0", 64'(cq1[0]), 64'(xa + 15));
      check_eq("t3_cmp1", 64'(cq1[1]), 64'(xb + 15));
      check_eq("t3_cmp2", 64'(cq1[2]), 64'(xd + 15));
    end
    check_eq("t3_cnt_end", 64'(cnt1), 64'd0);
    sel = 1'b0;

    // 4: backpressure in the middle of an 8-beat burst
    wq0.delete();
    send(cmd_pd(32'h2000_0040, 13'd7, 1'b0));
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        valid = 1'b1; pd = dat_pd(64'hC0DE_0000 + 64'(i), 1'b0); stall = 1'b1;
        idle(4);
        stall = 1'b0;
      end
      send(dat_pd(64'hC0DE_0000 + 64'(i), 1'b0));
    end
    idle(4);
    check_eq("t4_nwr", 64'(wq0.size()), 64'd8);
    for (int i = 0; i < wq0.size(); i++) begin
      check_eq("t4_addr", 64'(wq0[i].a), 64'(32'h2000_0040 + 32'(8 * i)));
      check_eq("t4_data", wq0[i].d, 64'hC0DE_0000 + 64'(i));
    end
    if (wq0.size() == 8) check_eq("t4_gap", 64'(wq0[2].c - wq0[1].c), 64'd5);

    // 5: protocol errors
    wq0.delete();
    send(dat_pd(64'hDEAD, 1'b1));
    idle(3);
    check_eq("t5_perr", 64'(pe0), 64'd1);
    check_eq("t5_nwr_idle", 64'(wq0.size()), 64'd0);
    send(cmd_pd(32'h3000_0000, 13'd3, 1'b0));
    send(dat_pd(64'h30, 1'b0));
    send(dat_pd(64'h31, 1'b0));
    send(cmd_pd(32'h5000_0000, 13'd0, 1'b1));
    check_eq("t5_cnt_drop", 64'(cnt0), 64'd0);
    send(dat_pd(64'h32, 1'b0));
    send(dat_pd(64'h33, 1'b0));
    idle(3);
    check_eq("t5_nwr", 64'(wq0.size()), 64'd4);
    for (int i = 0; i < wq0.size(); i++) begin
      check_eq("t5_addr", 64'(wq0[i].a), 64'(32'h3000_0000 + 32'(8 * i)));
      check_eq("t5_data", wq0[i].d, 64'h30 + 64'(i));
    end
    check_eq("t5_perr_sticky", 64'(pe0), 64'd1);

    // 6: reset during beat 2 of a 6-beat burst with an ack in flight (dut1)
    sel = 1'b1;
    send(cmd_pd(32'h0000_0400, 13'd0, 1'b1));
    send(dat_pd(64'hE, 1'b0)); xe = last_xc;
    send(cmd_pd(32'h4000_0000, 13'd5, 1'b1));
    check_eq("t6_cnt_pre", 64'(cnt1), 64'd2);
    send(dat_pd(64'h40, 1'b0));
    send(dat_pd(64'h41, 1'b0));
    cq1.delete();
    valid = 1'b1; pd = dat_pd(64'h42, 1'b0); rstn = 1'b0;
    @(negedge clk);
    check_eq("t6_ready_rst", 64'(r1), 64'd0);
    idle(1);
    rstn = 1'b1; valid = 1'b0;
    check_eq("t6_we", 64'(we1), 64'd0);
    check_eq("t6_addr", 64'(wa1), 64'd0);
    check_eq("t6_data", wd1, 64'd0);
    check_eq("t6_mask", 64'(wm1), 64'd0);
    check_eq("t6_cnt", 64'(cnt1), 64'd0);
    check_eq("t6_cmp", 64'(cmp1), 64'd0);
    check_eq("t6_perr0", 64'(pe0), 64'd0);
    idle(xe + 20 - cyc);
    check_eq("t6_no_cmp", 64'(cq1.size()), 64'd0);
    send(cmd_pd(32'h0000_0800, 13'd0, 1'b1));
    check_eq("t6_fresh_cnt", 64'(cnt1), 64'd1);
    send(dat_pd(64'hF, 1'b0));
    idle(20);
    check_eq("t6_fresh_cmp", 64'(cq1.size()), 64'd1);
    check_eq("t6_cnt_end", 64'(cnt1), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
